sig_pulse_gen: RTL and testbench

- Programmable periodic pulse generator: the transmit-side counterpart of the strobe/period measurement unit.
- Drives a clean, registered square/pulse train on sig_o with configurable period, high width and start phase.
- Used to stimulate measurement channels (loop-back calibration) and as a reference source for strobe-timing checks.
- Config arrives through a valid/ready port. A new config is applied only on a period boundary, so no runt pulses are produced.

---
 rtl/sig_pulse_gen.sv | 222 ++++++++++++++++++++++
 tb/tb_sig_pulse_gen.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_pulse_gen.sv
// sig_pulse_gen: programmable periodic pulse generator.
//
// A config word (period, high, phase) is offered on a valid/ready port and
// held in a shadow register. The shadow moves into the active set only while
// idle or on the last LOW cycle, so a running train never gets a runt pulse.
// The first rising edge after a start comes 1+phase cycles after run_i is
// sampled high. Later periods are measured rising-to-rising and take exactly
// `period` cycles.
//
// Ports:
//   clk_i, arst_ni    clock, asynchronous active-low reset. Assertion is
//                     asynchronous; release is synchronised internally.
//   cfg_valid_i/ready cfg handshake. ready=0 while a shadow config is pending.
//   cfg_period_i      period in cycles (>= MIN_PERIOD)
//   cfg_high_i        high time in cycles (1 .. period-1)
//   cfg_phase_i       cycles from run start to the first rising edge
//   run_i             1 = generate, 0 = stop at the end of the current period
//   sig_o             registered output pulse train
//   busy_o            generator not idle
//   err_o             sticky: the last offered config was illegal
//   edge_cnt_o        rising edges since the last start (wraps)
//
// Optional feature, macro SIG_PULSE_GEN_BURST_EN: adds burst_len_i, which is
// captured with each config. A nonzero burst stops the generator after that
// many rising edges. run_i must then go low before a new start is accepted.

module sig_pulse_gen #(
    parameter int unsigned T_CNT_WIDTH = 32,
    parameter int unsigned MIN_PERIOD  = 4
) (
    input  logic                   clk_i,
    input  logic                   arst_ni,
    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    input  logic [T_CNT_WIDTH-1:0] cfg_period_i,
    input  logic [T_CNT_WIDTH-1:0] cfg_high_i,
    input  logic [T_CNT_WIDTH-1:0] cfg_phase_i,
`ifdef SIG_PULSE_GEN_BURST_EN
    input  logic [T_CNT_WIDTH-1:0] burst_len_i,
`endif
    input  logic                   run_i,
    output logic                   sig_o,
    output logic                   busy_o,
    output logic                   err_o,
    output logic [T_CNT_WIDTH-1:0] edge_cnt_o
);

    // state      | meaning
    // S_IDLE     | output low; loads pending config; waits for run_i
    // S_PHASE_WAIT | counting start phase before the first rising edge
    // S_HIGH     | output high for `high` cycles
    // S_LOW      | output low for `period-high` cycles; reload point
    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_PHASE_WAIT = 2'd1,
        S_HIGH       = 2'd2,
        S_LOW        = 2'd3
    } state_t;

    localparam logic [T_CNT_WIDTH-1:0] ONE     = T_CNT_WIDTH'(1);
    localparam logic [T_CNT_WIDTH-1:0] MIN_PER = T_CNT_WIDTH'(MIN_PERIOD);

    logic [1:0]             r_rst_sync;
    logic                   w_rst_n;
    state_t                 r_state, w_nxt;
    logic [T_CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic                   w_cnt_zero;
    logic                   r_pending, r_act_vld, r_sig, r_err;
    logic [T_CNT_WIDTH-1:0] r_sh_high_m1, r_sh_low_m1, r_sh_phase;
    logic [T_CNT_WIDTH-1:0] r_act_high_m1, r_act_low_m1, r_act_phase;
    logic [T_CNT_WIDTH-1:0] r_edge_cnt;
    logic                   w_cfg_fire, w_cfg_legal, w_xfer, w_start;
    logic                   w_burst_done, w_burst_lock;

    // The reset asserts asynchronously and releases on a clock edge.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_cfg_fire  = cfg_valid_i & ~r_pending;
    assign w_cfg_legal = (cfg_period_i >= MIN_PER) && (cfg_high_i != '0) &&
                         (cfg_high_i < cfg_period_i);
    assign w_cnt_zero  = (r_cnt == '0);

    // Shadow stores the lengths as N-1. LOW = period-high is computed once
    // here, so no subtractor sits in the counter compare path.
    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sh_high_m1 <= '0;
            r_sh_low_m1  <= '0;
            r_sh_phase   <= '0;
        end else if (w_cfg_fire && w_cfg_legal) begin
            r_sh_high_m1 <= cfg_high_i - ONE;
            r_sh_low_m1  <= cfg_period_i - cfg_high_i - ONE;
            r_sh_phase   <= cfg_phase_i;
        end
    end

    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pending     <= 1'b0;
            r_err         <= 1'b0;
            r_act_vld     <= 1'b0;
            r_act_high_m1 <= '0;
            r_act_low_m1  <= '0;
            r_act_phase   <= '0;
        end else begin
            if (w_xfer) begin
                r_pending     <= 1'b0;
                r_act_vld     <= 1'b1;
                r_act_high_m1 <= r_sh_high_m1;
                r_act_low_m1  <= r_sh_low_m1;
                r_act_phase   <= r_sh_phase;
            end else if (w_cfg_fire && w_cfg_legal) begin
                r_pending <= 1'b1;
            end
            if (w_cfg_fire) r_err <= ~w_cfg_legal;
        end
    end

`ifdef SIG_PULSE_GEN_BURST_EN
    logic [T_CNT_WIDTH-1:0] r_sh_burst, r_act_burst;
    logic                   r_burst_lock;

    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sh_burst   <= '0;
            r_act_burst  <= '0;
            r_burst_lock <= 1'b0;
        end else begin
            if (w_cfg_fire && w_cfg_legal) r_sh_burst <= burst_len_i;
            if (w_xfer) r_act_burst <= r_sh_burst;
            // The lock is held until run_i drops, so a new start needs a fresh 0->1 on run_i.
            if (!run_i)
                r_burst_lock <= 1'b0;
            else if (r_state == S_LOW && w_cnt_zero && w_burst_done)
                r_burst_lock <= 1'b1;
        end
    end
    assign w_burst_done = (r_act_burst != '0) && (r_edge_cnt >= r_act_burst);
    assign w_burst_lock = r_burst_lock;
`else
    assign w_burst_done = 1'b0;
    assign w_burst_lock = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_sig      <= 1'b0;
            r_edge_cnt <= '0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sig   <= (w_nxt == S_HIGH);
            if (w_start)
                r_edge_cnt <= '0;
            else if (w_nxt == S_HIGH && r_state != S_HIGH)
                r_edge_cnt <= r_edge_cnt + ONE;
        end
    end

    always_comb begin
        w_nxt     = r_state;
        w_cnt_nxt = r_cnt;
        w_xfer    = 1'b0;
        w_start   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_xfer = r_pending;
                // A config loaded on this same edge is already usable: take the phase from the shadow.
                if (run_i && (r_act_vld || r_pending) && !w_burst_lock) begin
                    w_nxt     = S_PHASE_WAIT;
                    w_start   = 1'b1;
                    w_cnt_nxt = r_pending ? r_sh_phase : r_act_phase;
                end
            end
            S_PHASE_WAIT: begin
                if (!run_i) begin
                    w_nxt = S_IDLE;
                end else if (w_cnt_zero) begin
                    w_nxt     = S_HIGH;
                    w_cnt_nxt = r_act_high_m1;
                end else begin
                    w_cnt_nxt = r_cnt - ONE;
                end
            end
            S_HIGH: begin
                if (w_cnt_zero) begin
                    w_nxt     = S_LOW;
                    w_cnt_nxt = r_act_low_m1;
                end else begin
                    w_cnt_nxt = r_cnt - ONE;
                end
            end
            S_LOW: begin
                if (w_cnt_zero) begin
                    w_xfer = r_pending;
                    if (run_i && !w_burst_done) begin
                        w_nxt     = S_HIGH;
                        w_cnt_nxt = r_pending ? r_sh_high_m1 : r_act_high_m1;
                    end else begin
                        w_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - ONE;
                end
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    assign cfg_ready_o = ~r_pending;
    assign sig_o       = r_sig;
    assign busy_o      = (r_state != S_IDLE);
    assign err_o       = r_err;
    assign edge_cnt_o  = r_edge_cnt;

endmodule

// File: tb/tb_sig_pulse_gen.sv
module tb_sig_pulse_gen;
    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         arst_ni = 1'b0;
    logic         cfg_valid_i = 1'b0;
    logic         run_i = 1'b0;
    logic [W-1:0] cfg_period_i = '0;
    logic [W-1:0] cfg_high_i = '0;
    logic [W-1:0] cfg_phase_i = '0;
`ifdef SIG_PULSE_GEN_BURST_EN
    logic [W-1:0] burst_len_i = '0;
`endif
    logic         cfg_ready_o, sig_o, busy_o, err_o;
    logic [W-1:0] edge_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int q_rise[$];
    int q_fall[$];
    logic mon_prev = 1'b0;

    typedef struct {
        int hi;
        int per;
    } pulse_t;
    pulse_t exp_q[$];

    sig_pulse_gen #(.T_CNT_WIDTH(W), .MIN_PERIOD(4)) dut (
        .clk_i        (clk_i),
        .arst_ni      (arst_ni),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_period_i (cfg_period_i),
        .cfg_high_i   (cfg_high_i),
        .cfg_phase_i  (cfg_phase_i),
`ifdef SIG_PULSE_GEN_BURST_EN
        .burst_len_i  (burst_len_i),
`endif
        .run_i        (run_i),
        .sig_o        (sig_o),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .edge_cnt_o   (edge_cnt_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Record the posedge index of every rising and falling edge of sig_o.
    always @(negedge clk_i) begin
        if (sig_o && !mon_prev) q_rise.push_back(cyc);
        if (!sig_o && mon_prev) q_fall.push_back(cyc);
        mon_prev = sig_o;
    end

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_cfg(input int p, input int h, input int ph);
        cfg_period_i = p;
        cfg_high_i   = h;
        cfg_phase_i  = ph;
        cfg_valid_i  = 1'b1;
        tick();
        cfg_valid_i  = 1'b0;
    endtask

    task automatic clear_mon();
        q_rise.delete();
        q_fall.delete();
    endtask

    task automatic wait_rises(input int n, input string tag);
        int k = 0;
        while (q_rise.size() < n && k < 400) begin
            tick();
            k++;
        end
        chk({tag, " rise count"}, 64'(q_rise.size() >= n), 64'd1);
    endtask

    task automatic wait_sig_rise(output int t, output logic rdy_before);
        logic p;
        int k = 0;
        p = sig_o;
        t = -1;
        rdy_before = cfg_ready_o;
        while (k < 400) begin
            rdy_before = cfg_ready_o;
            tick();
            k++;
            if (sig_o && !p) begin
                t = cyc;
                break;
            end
            p = sig_o;
        end
        chk("sig rise seen", 64'(t >= 0), 64'd1);
    endtask

    task automatic wait_idle(output int t);
        int k = 0;
        while (busy_o && k < 400) begin
            tick();
            k++;
        end
        t = cyc;
        chk("return to idle", 64'(busy_o), 64'd0);
    endtask

    task automatic check_pulses(input string tag);
        pulse_t e;
        int i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (i + 1 < q_rise.size() && i < q_fall.size()) begin
                chk({tag, " high width"}, 64'(q_fall[i] - q_rise[i]), 64'(e.hi));
                chk({tag, " period"}, 64'(q_rise[i+1] - q_rise[i]), 64'(e.per));
            end else begin
                chk({tag, " pulse missing"}, 64'd0, 64'd1);
            end
            i++;
        end
    endtask

    initial begin
        int   t, t_run, t_idle, n;
        logic rdy_b;

        // Reset values, checked while held and after release.
        repeat (3) tick();
        chk("rst sig_o", 64'(sig_o), 64'd0);
        chk("rst busy_o", 64'(busy_o), 64'd0);
        chk("rst err_o", 64'(err_o), 64'd0);
        chk("rst cfg_ready_o", 64'(cfg_ready_o), 64'd1);
        chk("rst edge_cnt_o", 64'(edge_cnt_o), 64'd0);
        arst_ni = 1'b1;
        repeat (4) tick();
        chk("post-rst busy_o", 64'(busy_o), 64'd0);
        chk("post-rst ready", 64'(cfg_ready_o), 64'd1);

        // Basic train, period 10 / high 3 / phase 0.
        send_cfg(10, 3, 0);
        chk("t1 ready after capture", 64'(cfg_ready_o), 64'd0);
        tick();
        chk("t1 ready after load", 64'(cfg_ready_o), 64'd1);
        clear_mon();
        run_i = 1'b1;
        t_run = cyc + 1;
        repeat (4) exp_q.push_back('{hi: 3, per: 10});
        wait_rises(5, "t1");
        chk("t1 first rise latency", 64'(q_rise.size() > 0 ? q_rise[0] - t_run : -1), 64'd1);
        chk("t1 edge_cnt after 5", 64'(edge_cnt_o), 64'd5);
        check_pulses("t1");
        run_i = 1'b0;
        wait_idle(t_idle);
        chk("t1 idle sig_o", 64'(sig_o), 64'd0);

        // Illegal configs are dropped and flag err_o.
        send_cfg(3, 1, 0);
        chk("t2 err period<min", 64'(err_o), 64'd1);
        chk("t2 ready period<min", 64'(cfg_ready_o), 64'd1);
        send_cfg(10, 10, 0);
        chk("t2 err high=period", 64'(err_o), 64'd1);
        chk("t2 ready high=period", 64'(cfg_ready_o), 64'd1);
        chk("t2 sig unchanged", 64'(sig_o), 64'd0);
        chk("t2 busy unchanged", 64'(busy_o), 64'd0);
        send_cfg(10, 5, 0);
        chk("t2 err cleared", 64'(err_o), 64'd0);
        tick();

        // Reload mid-HIGH takes effect only at the period boundary.
        clear_mon();
        run_i = 1'b1;
        wait_sig_rise(t, rdy_b);
        repeat (2) tick();
        send_cfg(20, 2, 0);
        chk("t3 ready while pending", 64'(cfg_ready_o), 64'd0);
        wait_sig_rise(t, rdy_b);
        chk("t3 ready before reload", 64'(rdy_b), 64'd0);
        chk("t3 ready after reload", 64'(cfg_ready_o), 64'd1);
        exp_q.push_back('{hi: 5, per: 10});
        exp_q.push_back('{hi: 2, per: 20});
        exp_q.push_back('{hi: 2, per: 20});
        wait_rises(4, "t3");
        check_pulses("t3");
        run_i = 1'b0;
        wait_idle(t_idle);

        // Start phase of 7, then a run_i drop during PHASE_WAIT.
        send_cfg(10, 3, 7);
        tick();
        run_i = 1'b1;
        t_run = cyc + 1;
        wait_sig_rise(t, rdy_b);
        chk("t4 phase latency", 64'(t - t_run), 64'd8);
        run_i = 1'b0;
        wait_idle(t_idle);
        run_i = 1'b1;
        tick();
        chk("t4 busy in phase wait", 64'(busy_o), 64'd1);
        repeat (2) tick();
        run_i = 1'b0;
        n = q_rise.size();
        tick();
        chk("t4 busy after drop", 64'(busy_o), 64'd0);
        repeat (12) tick();
        chk("t4 no pulse after drop", 64'(q_rise.size()), 64'(n));
        chk("t4 sig low", 64'(sig_o), 64'd0);

        // run_i drop on the second HIGH cycle: the period completes, then IDLE.
        send_cfg(8, 4, 0);
        tick();
        clear_mon();
        run_i = 1'b1;
        wait_sig_rise(t, rdy_b);
        tick();
        run_i = 1'b0;
        wait_idle(t_idle);
        chk("t5 rise to idle", 64'(t_idle - t), 64'd8);
        chk("t5 high width", 64'(q_fall.size() > 0 ? q_fall[0] - t : -1), 64'd4);
        chk("t5 single edge", 64'(edge_cnt_o), 64'd1);
        chk("t5 idle sig_o", 64'(sig_o), 64'd0);

        // Reset asserted mid-HIGH with a config pending.
        run_i = 1'b1;
        wait_sig_rise(t, rdy_b);
        send_cfg(8, 2, 0);
        chk("t6 ready pending", 64'(cfg_ready_o), 64'd0);
        arst_ni = 1'b0;
        #1;
        chk("t6 rst sig_o", 64'(sig_o), 64'd0);
        chk("t6 rst ready", 64'(cfg_ready_o), 64'd1);
        chk("t6 rst edge_cnt", 64'(edge_cnt_o), 64'd0);
        chk("t6 rst busy", 64'(busy_o), 64'd0);
        tick();
        arst_ni = 1'b1;
        repeat (6) tick();
        chk("t6 no cfg, stays idle", 64'(busy_o), 64'd0);
        run_i = 1'b0;
        tick();

`ifdef SIG_PULSE_GEN_BURST_EN
        // Burst of 3 with run_i held high, then a restart via a run_i toggle.
        burst_len_i = 3;
        send_cfg(6, 2, 0);
        burst_len_i = 0;
        tick();
        clear_mon();
        run_i = 1'b1;
        repeat (40) tick();
        chk("t7 burst pulses", 64'(q_rise.size()), 64'd3);
        chk("t7 burst idle", 64'(busy_o), 64'd0);
        chk("t7 burst edge_cnt", 64'(edge_cnt_o), 64'd3);
        repeat (10) tick();
        chk("t7 no restart", 64'(q_rise.size()), 64'd3);
        run_i = 1'b0;
        repeat (2) tick();
        run_i = 1'b1;
        wait_sig_rise(t, rdy_b);
        tick();
        chk("t7 restart pulse", 64'(q_rise.size()), 64'd4);
        run_i = 1'b0;
        wait_idle(t_idle);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
